// File: rtl/dataslot_load_sequencer_pkg.sv
// Shared types for the boot-time dataslot load sequencer.
package dataslot_load_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StNext,
    StDone,
    StFail
  } dls_state_e;

  typedef struct packed {
    logic [15:0] slot_id;
    logic [31:0] offset;
    logic [31:0] addr;
    logic [31:0] length;
  } dataslot_cmd_t;

  localparam int unsigned RetryW    = 3;
  localparam int unsigned FailSlotW = 4;

endpackage

// File: rtl/dataslot_load_sequencer.sv
// Walks the dataslot table at boot, issuing one core_dataslot_read command per non-empty slot,
// retrying errors/timeouts, then pulses ready_to_run or reports the failing slot.
module dataslot_load_sequencer
  import dataslot_load_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned MAX_RETRIES = 2,
  parameter int unsigned TIMEOUT_W   = 26
) (
  input  logic                    clk_74a,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [NUM_SLOTS*16-1:0] slot_id,
  input  logic [NUM_SLOTS*32-1:0] slot_addr,
  input  logic [NUM_SLOTS*32-1:0] slot_len,
  output logic                    rd_valid,
  output logic [15:0]             rd_slot_id,
  output logic [31:0]             rd_offset,
  output logic [31:0]             rd_addr,
  output logic [31:0]             rd_length,
  input  logic                    rd_ack,
  input  logic                    rd_done,
  input  logic                    rd_err,
  output logic                    ready_to_run,
  output logic                    busy,
  output logic                    fail,
  output logic [3:0]              fail_slot
);

  localparam int unsigned       IdxW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_SLOTS - 1);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRIES);

  logic [15:0] tbl_id   [NUM_SLOTS];
  logic [31:0] tbl_addr [NUM_SLOTS];
  logic [31:0] tbl_len  [NUM_SLOTS];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_tbl
    assign tbl_id[i]   = slot_id[16*i +: 16];
    assign tbl_addr[i] = slot_addr[32*i +: 32];
    assign tbl_len[i]  = slot_len[32*i +: 32];
  end

  dls_state_e           state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  dataslot_cmd_t        cmd_q, cmd_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 fail_q, fail_d;
  logic [FailSlotW-1:0] fail_slot_q, fail_slot_d;
  logic                 rtr_q, rtr_d;
  logic                 pend_q, pend_d;
  logic                 pend_err_q, pend_err_d;

  logic [TIMEOUT_W-1:0] timer_q;
  logic                 timer_clr, timer_inc, timeout;
  logic                 cpl, cpl_err;

  assign timeout = &timer_q;
  // A done captured on the ack cycle is replayed as the first WAIT completion.
  assign cpl     = rd_done | pend_q;
  assign cpl_err = pend_q ? pend_err_q : rd_err;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    cmd_d       = cmd_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    fail_d      = fail_q;
    fail_slot_d = fail_slot_q;
    rtr_d       = 1'b0;
    pend_d      = 1'b0;
    pend_err_d  = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          idx_d       = '0;
          retry_d     = '0;
          fail_d      = 1'b0;
          fail_slot_d = '0;
          busy_d      = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        cmd_d.slot_id = tbl_id[idx_q];
        cmd_d.offset  = '0;
        cmd_d.addr    = tbl_addr[idx_q];
        cmd_d.length  = tbl_len[idx_q];
        if (tbl_len[idx_q] == '0) begin
          state_d = StNext;
        end else begin
          valid_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (rd_ack) begin
          valid_d    = 1'b0;
          timer_clr  = 1'b1;
          pend_d     = rd_done;
          pend_err_d = rd_err;
          state_d    = StWait;
        end
      end
      StWait: begin
        timer_inc = 1'b1;
        if (cpl && !cpl_err) begin
          state_d = StNext;
        end else if (cpl || timeout) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + 1'b1;
            valid_d = 1'b1;
            state_d = StIssue;
          end else begin
            fail_d      = 1'b1;
            fail_slot_d = FailSlotW'(idx_q);
            busy_d      = 1'b0;
            state_d     = StFail;
          end
        end
      end
      StNext: begin
        retry_d = '0;
        if (idx_q == LastIdx) begin
          rtr_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      retry_q     <= '0;
      cmd_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_slot_q <= '0;
      rtr_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
      fail_slot_q <= fail_slot_d;
      rtr_q       <= rtr_d;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
    end
  end

  // Per-command timeout; saturates at all-ones so a late host cannot wrap it.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (timer_clr) begin
      timer_q <= '0;
    end else if (timer_inc && !timeout) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign rd_valid     = valid_q;
  assign rd_slot_id   = cmd_q.slot_id;
  assign rd_offset    = cmd_q.offset;
  assign rd_addr      = cmd_q.addr;
  assign rd_length    = cmd_q.length;
  assign ready_to_run = rtr_q;
  assign busy         = busy_q;
  assign fail         = fail_q;
  assign fail_slot    = fail_slot_q;

endmodule

// File: tb/tb_dataslot_load_sequencer.sv
// Randomised host model driving the load sequencer, checked against a command-level model.
module tb_dataslot_load_sequencer;

  localparam int NS   = 2;
  localparam int MAXR = 2;
  localparam int TW   = 4;

  // host response codes
  localparam int RespOk   = 0;
  localparam int RespErr  = 1;
  localparam int RespNone = 2;

  logic clk = 1'b0;
  logic reset_n, start;
  logic [NS*16-1:0] slot_id;
  logic [NS*32-1:0] slot_addr, slot_len;
  logic rd_valid, rd_ack, rd_done, rd_err;
  logic [15:0] rd_slot_id;
  logic [31:0] rd_offset, rd_addr, rd_length;
  logic ready_to_run, busy, fail;
  logic [3:0] fail_slot;

  always #5 clk = ~clk;

  dataslot_load_sequencer #(
    .NUM_SLOTS  (NS),
    .MAX_RETRIES(MAXR),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk_74a     (clk),
    .reset_n     (reset_n),
    .start       (start),
    .slot_id     (slot_id),
    .slot_addr   (slot_addr),
    .slot_len    (slot_len),
    .rd_valid    (rd_valid),
    .rd_slot_id  (rd_slot_id),
    .rd_offset   (rd_offset),
    .rd_addr     (rd_addr),
    .rd_length   (rd_length),
    .rd_ack      (rd_ack),
    .rd_done     (rd_done),
    .rd_err      (rd_err),
    .ready_to_run(ready_to_run),
    .busy        (busy),
    .fail        (fail),
    .fail_slot   (fail_slot)
  );

  logic [15:0] tbl_id   [NS];
  logic [31:0] tbl_addr [NS];
  logic [31:0] tbl_len  [NS];

  for (genvar i = 0; i < NS; i++) begin : g_tbl
    assign slot_id[16*i +: 16]   = tbl_id[i];
    assign slot_addr[32*i +: 32] = tbl_addr[i];
    assign slot_len[32*i +: 32]  = tbl_len[i];
  end

  typedef struct {
    logic [15:0] id;
    logic [31:0] addr;
    logic [31:0] len;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t e;
  int   plan[$];
  int   host_plan[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   exp_fail, exp_fail_slot, exp_rtr, exp_cmds;
  int   xfer_cnt = 0, rtr_cnt = 0;
  int   start_cyc = 0, first_valid_cyc = -1, last_done_cyc = 0, last_xfer_cyc = 0;
  int   done_to_valid = 0, xfer_to_valid = 0, rtr_cyc = 0;
  logic [15:0] first_xfer_id;
  bit   host_en;
  int   ack_min, ack_max, done_min, done_max;
  int   stray_want = 0, stray_served = 0;
  logic prev_valid, prev_ack, prev_rtr;
  logic [15:0] p_id;
  logic [31:0] p_addr, p_len;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Command-level model: which reads must appear, and how the sequence ends.
  task automatic build_expect();
    int k;
    int r;
    bit ok;
    cmd_t c;
    k = 0;
    exp_q.delete();
    exp_fail = 0;
    exp_fail_slot = 0;
    exp_cmds = 0;
    for (int i = 0; i < NS; i++) begin
      if (tbl_len[i] == 0) continue;
      ok = 0;
      for (int a = 0; a <= MAXR; a++) begin
        c.id = tbl_id[i];
        c.addr = tbl_addr[i];
        c.len = tbl_len[i];
        exp_q.push_back(c);
        exp_cmds++;
        r = (k < plan.size()) ? plan[k] : RespOk;
        k++;
        if (r == RespOk) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        exp_fail = 1;
        exp_fail_slot = i;
        break;
      end
    end
    exp_rtr = exp_fail ? 0 : 1;
  endtask

  // Host side of the read channel: ack after a random delay, answer per plan.
  initial begin : host
    int d;
    int r;
    rd_ack = 1'b0;
    rd_done = 1'b0;
    rd_err = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_served != stray_want) begin
        rd_done = 1'b1;
        rd_err = stray_served[0];
        @(negedge clk);
        rd_done = 1'b0;
        rd_err = 1'b0;
        stray_served++;
      end else if (host_en && reset_n && rd_valid) begin
        d = $urandom_range(ack_max, ack_min);
        repeat (d) @(negedge clk);
        r = (host_plan.size() > 0) ? host_plan.pop_front() : RespOk;
        rd_ack = 1'b1;
        d = $urandom_range(done_max, done_min);
        if (r != RespNone && d == 0) begin
          rd_done = 1'b1;
          rd_err = (r == RespErr);
        end
        @(negedge clk);
        rd_ack = 1'b0;
        rd_done = 1'b0;
        rd_err = 1'b0;
        if (r != RespNone && d > 0) begin
          repeat (d - 1) @(negedge clk);
          rd_done = 1'b1;
          rd_err = (r == RespErr);
          @(negedge clk);
          rd_done = 1'b0;
          rd_err = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model queue and the channel rules.
  initial begin : monitor
    prev_valid = 1'b0;
    prev_ack = 1'b0;
    prev_rtr = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_valid = 1'b0;
        prev_ack = 1'b0;
        prev_rtr = 1'b0;
      end else begin
        if (rd_valid) begin
          check("busy_while_valid", busy, 1);
          check("rd_offset_zero", rd_offset, 0);
          if (prev_valid && !prev_ack)
            check("cmd_stable", {rd_slot_id, rd_addr, rd_length}, {p_id, p_addr, p_len});
          if (!prev_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            done_to_valid = cyc - last_done_cyc;
            xfer_to_valid = cyc - last_xfer_cyc;
          end
          if (rd_ack) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            if (xfer_cnt == 1) first_xfer_id = rd_slot_id;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_cmd: got id 0x%0h, expected no command", rd_slot_id);
            end else begin
              e = exp_q.pop_front();
              check("cmd_fields", {rd_slot_id, rd_addr, rd_length}, {e.id, e.addr, e.len});
            end
          end
        end
        if (rd_done) last_done_cyc = cyc;
        if (ready_to_run) begin
          check("rtr_one_cycle", prev_rtr, 0);
          rtr_cnt++;
          rtr_cyc = cyc;
        end
        prev_valid = rd_valid;
        prev_ack = rd_ack;
        prev_rtr = ready_to_run;
        p_id = rd_slot_id;
        p_addr = rd_addr;
        p_len = rd_length;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    first_valid_cyc = -1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stray_done();
    stray_want++;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_cmd"}, {rd_slot_id, rd_offset, rd_addr, rd_length}, 0);
    check({tag, "_status"}, {ready_to_run, busy, fail, fail_slot}, 0);
  endtask

  task automatic set_tbl(input int i, input logic [15:0] id, input logic [31:0] addr,
                         input logic [31:0] len);
    tbl_id[i] = id;
    tbl_addr[i] = addr;
    tbl_len[i] = len;
  endtask

  task automatic run_scn(input string tag);
    int n;
    build_expect();
    host_plan = plan;
    xfer_cnt = 0;
    rtr_cnt = 0;
    pulse_start();
    #3;
    n = 0;
    while (rtr_cnt == 0 && !(fail && !busy) && n < 600) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({tag, "_finished"}, n < 600, 1);
    repeat (25) @(negedge clk);
    #3;
    check({tag, "_cmd_count"}, xfer_cnt, exp_cmds);
    check({tag, "_exp_drained"}, exp_q.size(), 0);
    check({tag, "_rtr_pulses"}, rtr_cnt, exp_rtr);
    check({tag, "_fail"}, fail, exp_fail);
    if (exp_fail != 0) check({tag, "_fail_slot"}, fail_slot, exp_fail_slot);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin : main
    int n;
    reset_n = 1'b1;
    start = 1'b0;
    host_en = 1'b1;
    ack_min = 0; ack_max = 0; done_min = 1; done_max = 1;
    for (int i = 0; i < NS; i++) set_tbl(i, 16'h0, 32'h0, 32'h0);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // two good loads, fixed host timing
    set_tbl(0, 16'd1, 32'h1000_0000, 32'h100);
    set_tbl(1, 16'd2, 32'h2000_0000, 32'h40);
    plan = '{RespOk, RespOk};
    ack_min = 0; ack_max = 0; done_min = 2; done_max = 2;
    run_scn("s1");
    check("s1_two_cmds", xfer_cnt, 2);
    check("s1_first_id", first_xfer_id, 16'd1);
    check("s1_start_to_valid", first_valid_cyc - start_cyc, 2);
    check("s1_done_to_valid", done_to_valid, 3);
    check("s1_done_to_rtr", rtr_cyc - last_done_cyc, 2);

    // empty entry 0 is skipped
    set_tbl(0, 16'd9, 32'h0, 32'h0);
    set_tbl(1, 16'd5, 32'h3000_0000, 32'h80);
    plan = '{RespOk};
    ack_min = 0; ack_max = 3; done_min = 1; done_max = 4;
    run_scn("s2");
    check("s2_one_cmd", xfer_cnt, 1);
    check("s2_id", first_xfer_id, 16'd5);

    // two errors then success on entry 0
    set_tbl(0, 16'd1, 32'h1000_0000, 32'h100);
    set_tbl(1, 16'd2, 32'h2000_0000, 32'h40);
    plan = '{RespErr, RespErr, RespOk, RespOk};
    run_scn("s3");
    check("s3_four_cmds", xfer_cnt, 4);
    check("s3_no_fail", fail, 0);

    // entry 1 never completes -> three attempts, then fail on slot 1
    plan = '{RespOk, RespNone, RespNone, RespNone};
    run_scn("s4");
    check("s4_four_cmds", xfer_cnt, 4);
    check("s4_fail_slot", fail_slot, 4'd1);
    check("s4_no_rtr", rtr_cnt, 0);
    check("s4_timeout_gap", (xfer_to_valid >= 15 && xfer_to_valid <= 18), 1);

    // ack and done on the same cycle, plus stray completions while not waiting
    stray_done();
    done_min = 0; done_max = 0;
    plan = '{RespOk, RespOk};
    run_scn("s5");
    check("s5_two_cmds", xfer_cnt, 2);
    stray_done();
    stray_done();
    repeat (10) @(negedge clk);
    #3;
    check("s5_stray_no_cmd", xfer_cnt, 2);
    check("s5_stray_no_rtr", rtr_cnt, 1);
    check("s5_stray_idle", {busy, rd_valid}, 2'b00);

    // reset while waiting on the host, then a fresh sequence
    ack_min = 0; ack_max = 2; done_min = 1; done_max = 3;
    set_tbl(0, 16'h11, 32'h4000_0000, 32'h20);
    set_tbl(1, 16'h22, 32'h5000_0000, 32'h30);
    plan = '{RespOk, RespNone};
    build_expect();
    host_plan = plan;
    xfer_cnt = 0;
    pulse_start();
    n = 0;
    while (xfer_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s6_reached_wait", n < 200, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #3 check_zero("s6_in_reset");
    repeat (2) @(negedge clk);
    exp_q.delete();
    host_plan.delete();
    reset_n = 1'b1;
    stray_done();
    plan = '{RespOk, RespOk};
    run_scn("s6");
    check("s6_restart_id", first_xfer_id, 16'h11);

    // randomized tables, host timing and responses
    ack_min = 0; ack_max = 3; done_min = 0; done_max = 4;
    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < NS; i++)
        set_tbl(i, 16'($urandom), $urandom,
                ($urandom_range(3) == 0) ? 32'h0 : 32'($urandom_range(4096, 1)));
      plan.delete();
      for (int k = 0; k < 6; k++) begin
        n = $urandom_range(9);
        plan.push_back((n < 6) ? RespOk : (n < 9) ? RespErr : RespNone);
      end
      run_scn("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
